// File: rtl/ntt_address_scheduler.sv
// ntt_address_scheduler: read/write address sequencer for a radix-2 NTT running on
// 4 butterfly units. Each cycle it issues 8 read addresses (a_i, b_i per BFU). The
// write-back addresses are the same addresses after a PIPE_DEPTH-deep delay line.
// A drain phase between stages keeps a stage from reading data still in flight.
// Optional feature macro: NTT_INVERSE_MODE_EN adds the `inverse` port, which selects
// Gentleman-Sande stage order (d grows from 1) instead of forward order (d shrinks to 1).

// Operand address pair for one BFU: inserting a 0 at bit k of the butterfly index
// gives a_i, and b_i sits exactly d = 2^k above it.
module ntt_bfu_addr #(
    parameter int LOGN = 10,
    parameter int LANE = 0
) (
    input  logic [LOGN-4:0] cnt,
    input  logic [3:0]      k,
    output logic [LOGN-1:0] a,
    output logic [LOGN-1:0] b
);
    logic [LOGN-1:0] j;
    logic [LOGN-1:0] d;
    logic [LOGN-1:0] low_mask;

    // Butterfly index j = 4*cnt + LANE, then split it around bit k
    always_comb begin
        j        = {1'b0, cnt, 2'(LANE)};
        d        = LOGN'(1) << k;
        low_mask = d - LOGN'(1);
        a        = ((j >> k) << (k + 4'd1)) | (j & low_mask);
        b        = a + d;
    end
endmodule

module ntt_address_scheduler #(
    parameter int LOGN       = 10,
    parameter int PIPE_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
`ifdef NTT_INVERSE_MODE_EN
    input  logic            inverse,
`endif
    output logic            busy,
    output logic            done,
    output logic [3:0]      stage,
    output logic            rd_valid,
    output logic [LOGN-1:0] rd_address_0,
    output logic [LOGN-1:0] rd_address_1,
    output logic [LOGN-1:0] rd_address_2,
    output logic [LOGN-1:0] rd_address_3,
    output logic [LOGN-1:0] rd_address_4,
    output logic [LOGN-1:0] rd_address_5,
    output logic [LOGN-1:0] rd_address_6,
    output logic [LOGN-1:0] rd_address_7,
    output logic            wr_valid,
    output logic [LOGN-1:0] wr_address_0,
    output logic [LOGN-1:0] wr_address_1,
    output logic [LOGN-1:0] wr_address_2,
    output logic [LOGN-1:0] wr_address_3,
    output logic [LOGN-1:0] wr_address_4,
    output logic [LOGN-1:0] wr_address_5,
    output logic [LOGN-1:0] wr_address_6,
    output logic [LOGN-1:0] wr_address_7
);
    localparam int NUM_BFU = 4;
    localparam int NUM_ADR = 2 * NUM_BFU;
    localparam int CNT_W   = LOGN - 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                                      state_q, state_d;
    logic [3:0]                                  stage_q, stage_d;
    logic [CNT_W-1:0]                            cnt_q, cnt_d;
    logic [4:0]                                  drain_q, drain_d;
    logic                                        inv_q;
    logic [PIPE_DEPTH-1:0]                       vld_pipe_q, vld_pipe_d;
    logic [PIPE_DEPTH-1:0][NUM_ADR-1:0][LOGN-1:0] adr_pipe_q, adr_pipe_d;

    logic [3:0]                   k;
    logic [NUM_ADR-1:0][LOGN-1:0] rd_adr_raw;
    logic [NUM_ADR-1:0][LOGN-1:0] rd_adr;

`ifdef NTT_INVERSE_MODE_EN
    logic inv_d;

    // Direction is latched with start and held for the whole transform
    always_comb begin
        inv_d = inv_q;
        if (state_q == S_IDLE && start) inv_d = inverse;
    end

    // Direction register
    always_ff @(posedge clk) begin
        if (!rst) inv_q <= 1'b0;
        else      inv_q <= inv_d;
    end
`else
    assign inv_q = 1'b0;
`endif

    // Butterfly span exponent for the current stage
    always_comb begin
        k = inv_q ? stage_q : (4'(LOGN - 1) - stage_q);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BFU; gi++) begin : g_bfu
            ntt_bfu_addr #(.LOGN(LOGN), .LANE(gi)) u_addr (
                .cnt (cnt_q),
                .k   (k),
                .a   (rd_adr_raw[2*gi]),
                .b   (rd_adr_raw[2*gi+1])
            );
        end
    endgenerate

    // Sequencer: next state, counters, and the read-issue strobe
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        rd_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = 4'd0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    rd_valid = 1'b1;
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_d = S_DRAIN;
                        drain_d = 5'(PIPE_DEPTH);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last drain cycle is the one in which the stage's final write lands
                if (drain_q <= 5'd1) begin
                    if (stage_q < 4'(LOGN - 1)) begin
                        state_d = S_RUN;
                        stage_d = stage_q + 4'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    drain_d = drain_q - 5'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read addresses are held at zero whenever no read is issued
    always_comb begin
        rd_adr = rd_valid ? rd_adr_raw : '0;
    end

    // Write-back delay line: slot 0 takes this cycle's read, the last slot is the write
    always_comb begin
        vld_pipe_d    = '0;
        adr_pipe_d    = '0;
        vld_pipe_d[0] = rd_valid;
        adr_pipe_d[0] = rd_adr;
        for (int p = 1; p < PIPE_DEPTH; p++) begin
            vld_pipe_d[p] = vld_pipe_q[p-1];
            adr_pipe_d[p] = adr_pipe_q[p-1];
        end
    end

    // State and delay-line registers; reset wipes in-flight writes too
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            vld_pipe_q <= '0;
            adr_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            vld_pipe_q <= vld_pipe_d;
            adr_pipe_q <= adr_pipe_d;
        end
    end

    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);
    assign stage = stage_q;

    assign rd_address_0 = rd_adr[0];
    assign rd_address_1 = rd_adr[1];
    assign rd_address_2 = rd_adr[2];
    assign rd_address_3 = rd_adr[3];
    assign rd_address_4 = rd_adr[4];
    assign rd_address_5 = rd_adr[5];
    assign rd_address_6 = rd_adr[6];
    assign rd_address_7 = rd_adr[7];

    assign wr_valid     = vld_pipe_q[PIPE_DEPTH-1];
    assign wr_address_0 = adr_pipe_q[PIPE_DEPTH-1][0];
    assign wr_address_1 = adr_pipe_q[PIPE_DEPTH-1][1];
    assign wr_address_2 = adr_pipe_q[PIPE_DEPTH-1][2];
    assign wr_address_3 = adr_pipe_q[PIPE_DEPTH-1][3];
    assign wr_address_4 = adr_pipe_q[PIPE_DEPTH-1][4];
    assign wr_address_5 = adr_pipe_q[PIPE_DEPTH-1][5];
    assign wr_address_6 = adr_pipe_q[PIPE_DEPTH-1][6];
    assign wr_address_7 = adr_pipe_q[PIPE_DEPTH-1][7];
endmodule

// File: tb/tb_ntt_address_scheduler.sv
// Bench for ntt_address_scheduler: a queue of expected read groups built from the
// butterfly index arithmetic, a write-side history that must reappear PD cycles
// later, and directed runs (plain, stalled, reset mid-drain) with literal anchors.
module tb_ntt_address_scheduler;
    localparam int LOGN = 10;
    localparam int PD   = 8;
    localparam int CPS  = (1 << LOGN) / 8;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, stall = 1'b0;
`ifdef NTT_INVERSE_MODE_EN
    logic inverse = 1'b0;
`endif
    logic busy, done, rd_valid, wr_valid;
    logic [3:0] stage;
    logic [LOGN-1:0] rd_address_0, rd_address_1, rd_address_2, rd_address_3;
    logic [LOGN-1:0] rd_address_4, rd_address_5, rd_address_6, rd_address_7;
    logic [LOGN-1:0] wr_address_0, wr_address_1, wr_address_2, wr_address_3;
    logic [LOGN-1:0] wr_address_4, wr_address_5, wr_address_6, wr_address_7;

    ntt_address_scheduler #(.LOGN(LOGN), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
`ifdef NTT_INVERSE_MODE_EN
        .inverse(inverse),
`endif
        .busy(busy), .done(done), .stage(stage), .rd_valid(rd_valid),
        .rd_address_0(rd_address_0), .rd_address_1(rd_address_1),
        .rd_address_2(rd_address_2), .rd_address_3(rd_address_3),
        .rd_address_4(rd_address_4), .rd_address_5(rd_address_5),
        .rd_address_6(rd_address_6), .rd_address_7(rd_address_7),
        .wr_valid(wr_valid),
        .wr_address_0(wr_address_0), .wr_address_1(wr_address_1),
        .wr_address_2(wr_address_2), .wr_address_3(wr_address_3),
        .wr_address_4(wr_address_4), .wr_address_5(wr_address_5),
        .wr_address_6(wr_address_6), .wr_address_7(wr_address_7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [LOGN-1:0] rda [8];
    logic [LOGN-1:0] wra [8];
    assign rda[0] = rd_address_0; assign rda[1] = rd_address_1;
    assign rda[2] = rd_address_2; assign rda[3] = rd_address_3;
    assign rda[4] = rd_address_4; assign rda[5] = rd_address_5;
    assign rda[6] = rd_address_6; assign rda[7] = rd_address_7;
    assign wra[0] = wr_address_0; assign wra[1] = wr_address_1;
    assign wra[2] = wr_address_2; assign wra[3] = wr_address_3;
    assign wra[4] = wr_address_4; assign wra[5] = wr_address_5;
    assign wra[6] = wr_address_6; assign wra[7] = wr_address_7;

    typedef struct packed {
        logic [3:0]                stg;
        logic [7:0][LOGN-1:0]      adr;
    } rd_t;

    rd_t exp_q [$];
    logic            hv [PD];
    logic [LOGN-1:0] ha [PD][8];

    int  nchk = 0, nerr = 0;
    bit  en = 1'b0;
    int  wr_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Every butterfly of every stage, in issue order: j = 4*cnt+i, a sits below b by d
    function automatic void load_model(input bit inv);
        rd_t e;
        int  kk, d, j, a;
        exp_q.delete();
        for (int s = 0; s < LOGN; s++) begin
            kk = inv ? s : (LOGN - 1 - s);
            d  = 1 << kk;
            for (int c = 0; c < CPS; c++) begin
                e.stg = 4'(s);
                for (int i = 0; i < 4; i++) begin
                    j = 4 * c + i;
                    a = (j / d) * (2 * d) + (j % d);
                    e.adr[2*i]   = LOGN'(a);
                    e.adr[2*i+1] = LOGN'(a + d);
                end
                exp_q.push_back(e);
            end
        end
    endfunction

    initial begin
        for (int p = 0; p < PD; p++) begin
            hv[p] = 1'b0;
            for (int i = 0; i < 8; i++) ha[p][i] = '0;
        end
    end

    // Per-cycle compare: read order vs model, writes vs reads PD cycles earlier
    always @(negedge clk) begin
        rd_t e;
        int  h;
        h = cyc % PD;
        if (en) begin
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rd_stage", stage, e.stg);
                    for (int i = 0; i < 8; i++)
                        chk($sformatf("rd_addr%0d", i), rda[i], e.adr[i]);
                end
            end
            if (stall && busy) chk("stall_blocks_rd", rd_valid, 0);
            if (done) chk("stage_at_done", stage, LOGN - 1);
            chk("wr_valid", wr_valid, hv[h]);
            for (int i = 0; i < 8; i++)
                chk($sformatf("wr_addr%0d", i), wra[i], ha[h][i]);
            if (wr_valid) wr_cnt++;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
        if (!rst) begin
            for (int p = 0; p < PD; p++) begin
                hv[p] = 1'b0;
                for (int i = 0; i < 8; i++) ha[p][i] = '0;
            end
        end else begin
            hv[h] = rd_valid;
            for (int i = 0; i < 8; i++) ha[h][i] = rda[i];
        end
    end

    task automatic at_cyc(input int c);
        do begin
            @(posedge clk); #2;
        end while (cyc < c);
    endtask

    task automatic do_start(input bit inv, output int t);
        @(posedge clk); #2;
`ifdef NTT_INVERSE_MODE_EN
        inverse = inv;
`endif
        start = 1'b1;
        t = cyc;
        load_model(inv);
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_addrs(input string nm, input int v0, input int v1, input int v2,
                             input int v3, input int v4, input int v5, input int v6,
                             input int v7);
        int lit [8];
        lit = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < 8; i++) chk($sformatf("%s_%0d", nm, i), rda[i], lit[i]);
    endtask

    task automatic chk_finish(input string nm, input int t, input int dcyc);
        chk({nm, "_done_cycle"}, done_cyc, t + dcyc);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_done_low_after"}, done, 0);
        chk({nm, "_wr_count"}, wr_cnt, LOGN * CPS);
        chk({nm, "_busy_cycles"}, busy_cnt, dcyc - 1);
        chk({nm, "_model_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int t;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        en  = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_rd_addr1", rd_address_1, 0);
        chk("rst_wr_addr7", wr_address_7, 0);

        // Run 1: plain forward transform with literal anchors
        do_start(1'b0, t);
        chk("r1_first_valid", rd_valid, 1);
        chk("r1_first_stage", stage, 0);
        chk_addrs("r1_first", 0, 512, 1, 513, 2, 514, 3, 515);
        at_cyc(t + 128);
        chk_addrs("r1_s0_last", 508, 1020, 509, 1021, 510, 1022, 511, 1023);
        at_cyc(t + 129);
        chk("r1_drain_rd", rd_valid, 0);
        chk("r1_drain_busy", busy, 1);
        at_cyc(t + 136);
        chk("r1_drain_end_rd", rd_valid, 0);
        chk("r1_drain_end_stage", stage, 0);
        at_cyc(t + 137);
        chk("r1_s1_stage", stage, 1);
        chk_addrs("r1_s1_first", 0, 256, 1, 257, 2, 258, 3, 259);
        at_cyc(t + 1 + 9 * 136);
        chk("r1_s9_stage", stage, 9);
        chk_addrs("r1_s9_first", 0, 1, 2, 3, 4, 5, 6, 7);
        wait_done(400);
        chk_finish("r1", t, 1361);

        // Run 2: ignored start while busy, five-cycle stall in stage 3
        do_start(1'b0, t);
        at_cyc(t + 100);
        start = 1'b1;
        at_cyc(t + 101);
        start = 1'b0;
        chk("r2_start_ignored_stage", stage, 0);
        at_cyc(t + 460);
        chk("r2_pre_stall_stage", stage, 3);
        stall = 1'b1;
        at_cyc(t + 462);
        chk("r2_stalled_rd", rd_valid, 0);
        at_cyc(t + 465);
        stall = 1'b0;
        wait_done(2000);
        chk_finish("r2", t, 1366);

        // Run 3: reset in stage 4 drain aborts everything
        do_start(1'b0, t);
        at_cyc(t + 675);
        chk("r3_in_drain_stage", stage, 4);
        chk("r3_in_drain_rd", rd_valid, 0);
        rst = 1'b0;
        at_cyc(t + 676);
        rst = 1'b1;
        exp_q.delete();
        wr_cnt = 0;
        chk("r3_rst_busy", busy, 0);
        chk("r3_rst_stage", stage, 0);
        chk("r3_rst_wr_valid", wr_valid, 0);
        chk("r3_rst_wr_addr0", wr_address_0, 0);
        at_cyc(t + 700);
        chk("r3_no_late_wr", wr_cnt, 0);
        chk("r3_idle_busy", busy, 0);
        chk("r3_no_done", done_cnt, 0);

        // Run 4: clean transform after the abort
        do_start(1'b0, t);
        chk_addrs("r4_first", 0, 512, 1, 513, 2, 514, 3, 515);
        wait_done(1500);
        chk_finish("r4", t, 1361);

`ifdef NTT_INVERSE_MODE_EN
        // Run 5: inverse order, spans grow from 1
        do_start(1'b1, t);
        chk_addrs("r5_s0_first", 0, 1, 2, 3, 4, 5, 6, 7);
        at_cyc(t + 1 + 9 * 136);
        chk_addrs("r5_s9_first", 0, 512, 1, 513, 2, 514, 3, 515);
        wait_done(400);
        chk_finish("r5", t, 1361);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
